uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL use these parameters:
- GAP_W, default 4, width of cfg_gap_bits.
- TICKS_PER_BIT, default 16, tick events per bit period.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick  in  1  baud oversample signal, synchronous to clk.
- req_valid  in  2  requester 0/1 has a byte pending.
- req_data0  in  8  requester 0 byte.
- req_data1  in  8  requester 1 byte.
- req_ready  out  2  one-hot accept pulse per requester.
- cfg_data_bit_num  in  2  frame data length code.
- cfg_stop_bit_num  in  1  stop bit count code.
- cfg_parity_en  in  1  parity enable.
- cfg_parity_type  in  1  0 even, 1 odd.
- cfg_gap_bits  in  GAP_W  idle bit periods inserted between frames.
- cts_n  in  1  peer clear-to-send, active-low.
- tx_data  out  8  byte to the transmitter.
- start_tx  out  1  transmitter start request.
- data_bit_num  out  2  latched frame config to the transmitter.
- stop_bit_num  out  1  latched frame config to the transmitter.
- parity_en  out  1  latched frame config to the transmitter.
- parity_type  out  1  latched frame config to the transmitter.
- tx_done  in  1  transmitter frame-complete indication.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  requester owning the current or last frame.

Function
REQ-003 A tick event SHALL be a cycle where tick=1 and the registered previous tick=0.
REQ-004 The FSM SHALL have exactly four states: IDLE, START, WAIT_DONE, GAP.
REQ-005 In IDLE, when cts_n=0 and any req_valid bit is set, the block SHALL grant one requester that same cycle.
REQ-006 At grant, the block SHALL pulse req_ready[grant] for exactly one cycle.
REQ-007 At grant, the block SHALL register that requester's data into tx_data, register all cfg_* inputs into the config outputs, update grant_id, and enter START.
REQ-008 Arbitration SHALL be round-robin: with both valid, the requester not in grant_id wins; with one valid, that requester wins.
REQ-009 In IDLE with cts_n=1, the block SHALL grant nothing and req_ready SHALL stay 0.
REQ-010 start_tx SHALL be 1 exactly while in START.
REQ-011 START SHALL exit to WAIT_DONE on the cycle after the first tick event seen in START, so start_tx spans at least one full tick high phase.
REQ-012 WAIT_DONE SHALL exit on the rising edge of tx_done (tx_done=1 and registered prior tx_done=0), to GAP if cfg_gap_bits latched nonzero, else to IDLE.
REQ-013 A tx_done level already high on entry to WAIT_DONE SHALL NOT complete the frame.
REQ-014 GAP SHALL count gap_bits*TICKS_PER_BIT tick events, then enter IDLE.
REQ-015 The gap counter width SHALL be GAP_W+log2(TICKS_PER_BIT) bits with no overflow.
REQ-016 tx_data and the config outputs SHALL hold constant from grant until the next grant.
REQ-017 cfg_* changes outside a grant cycle SHALL NOT affect an in-flight frame.
REQ-018 cts_n SHALL be sampled only in IDLE; deassertion mid-frame SHALL NOT abort the frame.
REQ-019 req_valid dropping after grant SHALL NOT affect the in-flight frame.
REQ-020 At most one req_ready bit SHALL be high in any cycle.
REQ-021 busy SHALL be 1 in START, WAIT_DONE and GAP, and 0 in IDLE.

Reset
REQ-022 While rst_n=0, the block SHALL force: state=IDLE, req_ready=0, start_tx=0, tx_data=0, data_bit_num=2'b11, stop_bit_num=0, parity_en=0, parity_type=0, busy=0, grant_id=1 (requester 0 wins first), and all counters and edge registers cleared.
REQ-023 Reset asserted in any state SHALL take effect immediately, without waiting for clk.
REQ-024 No grant SHALL occur in the first clk cycle after rst_n rises.

Structure
REQ-025 A shared package uart_pkg SHALL hold the FSM state enum, the TICKS_PER_BIT constant, and the data_bit_num encoding constants.
REQ-026 One sub-module uart_rr_arb2 SHALL implement the 2-way round-robin pointer and one-hot grant; the FSM, edge detection and counters SHALL stay in uart_tx_sched.

Verification
REQ-027 Single request: req_valid=01, req_data0=A5, cts_n=0 -> req_ready=01 for one cycle, tx_data=A5, start_tx high through one tick event, busy=1 until tx_done rises.
REQ-028 Both valid continuously, gap=0 -> grants alternate 0,1,0,1 and four req_ready pulses are one-hot.
REQ-029 cts_n=1 with req_valid=11 for 1000 cycles -> no req_ready and start_tx=0; cts_n=0 -> grant within 1 cycle.
REQ-030 cfg_gap_bits=2 -> after the tx_done rise, exactly 32 tick events elapse before the next grant.
REQ-031 cfg_parity_en toggled during WAIT_DONE -> parity_en output unchanged until the next grant.
REQ-032 rst_n pulsed low in WAIT_DONE -> all outputs at reset values immediately; a stale tx_done high after release causes no spurious transition.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// default oversample ratio and the frame data-length codes.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } state_t;

   localparam int unsigned UART_TICKS_PER_BIT = 16;

   // data_bit_num codes: number of data bits in a frame
   localparam logic [1:0] DBN_5 = 2'b00;
   localparam logic [1:0] DBN_6 = 2'b01;
   localparam logic [1:0] DBN_7 = 2'b10;
   localparam logic [1:0] DBN_8 = 2'b11;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_req          : request vector
//   i_accept       : grant is taken this cycle; pointer moves to winner
//   o_gnt_c        : one-hot grant (combinational)
//   o_gnt_id_c     : index of the winner (combinational)
//   o_last_id      : registered index of the last accepted requester
module uart_rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_gnt_c,
   output logic       o_gnt_id_c,
   output logic       o_last_id
);

   logic r_last;

   // Winner select: contended -> the one not granted last time
   always_comb begin
      o_gnt_id_c = 1'b0;
      o_gnt_c    = 2'b00;
      case (i_req)
         2'b01:   o_gnt_id_c = 1'b0;
         2'b10:   o_gnt_id_c = 1'b1;
         2'b11:   o_gnt_id_c = ~r_last;
         default: o_gnt_id_c = 1'b0;
      endcase
      if (|i_req) begin
         o_gnt_c = o_gnt_id_c ? 2'b10 : 2'b01;
      end
   end

   // Pointer resets to 1 so requester 0 wins the first contention
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last <= 1'b1;
      end else if (i_accept) begin
         r_last <= o_gnt_id_c;
      end
   end

   assign o_last_id = r_last;

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: arbitrates two byte requesters, latches the
// frame config, hands the byte to the transmitter with a start strobe,
// waits for frame completion and optionally inserts idle bit periods.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   tick                : baud oversample level; rising edge = tick event
//   req_valid/req_data* : two byte requesters; req_ready is the accept pulse
//   cfg_*               : frame config, sampled only at grant
//   cts_n               : peer clear-to-send, sampled only in IDLE
//   tx_data, start_tx, data_bit_num, stop_bit_num, parity_en, parity_type :
//                         to the transmitter
//   tx_done             : transmitter frame-complete level; rising edge used
//   busy, grant_id      : status
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned GAP_W         = 4,
   parameter int unsigned TICKS_PER_BIT = UART_TICKS_PER_BIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic [1:0]       req_valid,
   input  logic [7:0]       req_data0,
   input  logic [7:0]       req_data1,
   output logic [1:0]       req_ready,
   input  logic [1:0]       cfg_data_bit_num,
   input  logic             cfg_stop_bit_num,
   input  logic             cfg_parity_en,
   input  logic             cfg_parity_type,
   input  logic [GAP_W-1:0] cfg_gap_bits,
   input  logic             cts_n,
   output logic [7:0]       tx_data,
   output logic             start_tx,
   output logic [1:0]       data_bit_num,
   output logic             stop_bit_num,
   output logic             parity_en,
   output logic             parity_type,
   input  logic             tx_done,
   output logic             busy,
   output logic             grant_id
);

   localparam int unsigned TPB_W = $clog2(TICKS_PER_BIT);
   localparam int unsigned CNT_W = GAP_W + TPB_W;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_tick_prev;
   logic               r_done_prev;
   logic               r_tick_seen;
   logic               w_tick_seen_nxt;
   logic [CNT_W-1:0]   r_gap_cnt;
   logic [CNT_W-1:0]   w_gap_cnt_nxt;
   logic [CNT_W-1:0]   w_gap_last;
   logic [GAP_W-1:0]   r_gap;
   logic               r_arm;
   logic               w_accept;
   logic               w_tick_ev;
   logic               w_done_rise;
   logic [1:0]         w_gnt;
   logic               w_gnt_id;
   logic [1:0]         r_req_ready;
   logic [7:0]         r_tx_data;
   logic [1:0]         r_dbn;
   logic               r_stop;
   logic               r_par_en;
   logic               r_par_type;
   logic               r_start_tx;
   logic               r_busy;

   uart_rr_arb2 u_arb (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req      (req_valid),
      .i_accept   (w_accept),
      .o_gnt_c    (w_gnt),
      .o_gnt_id_c (w_gnt_id),
      .o_last_id  (grant_id)
   );

   assign w_tick_ev   = tick & ~r_tick_prev;
   assign w_done_rise = tx_done & ~r_done_prev;
   // Last count of the gap; gap of zero never reaches GAP
   assign w_gap_last  = (CNT_W'(r_gap) * CNT_W'(TICKS_PER_BIT)) - CNT_W'(1);

   // Next-state logic
   always_comb begin
      w_state_nxt     = r_state;
      w_accept        = 1'b0;
      w_tick_seen_nxt = r_tick_seen;
      w_gap_cnt_nxt   = r_gap_cnt;
      case (r_state)
         ST_IDLE: begin
            // r_arm blocks a grant on the first cycle out of reset
            if (r_arm && !cts_n && (|req_valid)) begin
               w_accept        = 1'b1;
               w_tick_seen_nxt = 1'b0;
               w_state_nxt     = ST_START;
            end
         end
         ST_START: begin
            // Hold start_tx one cycle past the first tick event
            if (r_tick_seen) begin
               w_tick_seen_nxt = 1'b0;
               w_state_nxt     = ST_WAIT_DONE;
            end else if (w_tick_ev) begin
               w_tick_seen_nxt = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (w_done_rise) begin
               w_gap_cnt_nxt = '0;
               w_state_nxt   = (r_gap != '0) ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            if (w_tick_ev) begin
               if (r_gap_cnt == w_gap_last) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_gap_cnt_nxt = r_gap_cnt + CNT_W'(1);
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State, edge history and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_tick_prev <= 1'b0;
         r_done_prev <= 1'b0;
         r_tick_seen <= 1'b0;
         r_gap_cnt   <= '0;
         r_arm       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tick_prev <= tick;
         r_done_prev <= tx_done;
         r_tick_seen <= w_tick_seen_nxt;
         r_gap_cnt   <= w_gap_cnt_nxt;
         r_arm       <= 1'b1;
      end
   end

   // Frame payload and config latched only at grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_ready <= 2'b00;
         r_tx_data   <= 8'h00;
         r_dbn       <= DBN_8;
         r_stop      <= 1'b0;
         r_par_en    <= 1'b0;
         r_par_type  <= 1'b0;
         r_gap       <= '0;
         r_start_tx  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_req_ready <= 2'b00;
         if (w_accept) begin
            r_req_ready <= w_gnt;
            r_tx_data   <= w_gnt_id ? req_data1 : req_data0;
            r_dbn       <= cfg_data_bit_num;
            r_stop      <= cfg_stop_bit_num;
            r_par_en    <= cfg_parity_en;
            r_par_type  <= cfg_parity_type;
            r_gap       <= cfg_gap_bits;
         end
         r_start_tx <= (w_state_nxt == ST_START);
         r_busy     <= (w_state_nxt != ST_IDLE);
      end
   end

   assign req_ready    = r_req_ready;
   assign tx_data      = r_tx_data;
   assign data_bit_num = r_dbn;
   assign stop_bit_num = r_stop;
   assign parity_en    = r_par_en;
   assign parity_type  = r_par_type;
   assign start_tx     = r_start_tx;
   assign busy         = r_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: stimulus pushes expected grants,
// a negedge monitor pops and compares whenever req_ready is presented.
module tb_uart_tx_sched;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic [1:0] req_valid;
   logic [7:0] req_data0;
   logic [7:0] req_data1;
   logic [1:0] req_ready;
   logic [1:0] cfg_data_bit_num;
   logic       cfg_stop_bit_num;
   logic       cfg_parity_en;
   logic       cfg_parity_type;
   logic [3:0] cfg_gap_bits;
   logic       cts_n;
   logic [7:0] tx_data;
   logic       start_tx;
   logic [1:0] data_bit_num;
   logic       stop_bit_num;
   logic       parity_en;
   logic       parity_type;
   logic       tx_done;
   logic       busy;
   logic       grant_id;

   typedef struct packed {
      logic       id;
      logic [7:0] data;
      logic [1:0] dbn;
      logic       stop;
      logic       pe;
      logic       pt;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   uart_tx_sched #(.GAP_W(4), .TICKS_PER_BIT(16)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .tick             (tick),
      .req_valid        (req_valid),
      .req_data0        (req_data0),
      .req_data1        (req_data1),
      .req_ready        (req_ready),
      .cfg_data_bit_num (cfg_data_bit_num),
      .cfg_stop_bit_num (cfg_stop_bit_num),
      .cfg_parity_en    (cfg_parity_en),
      .cfg_parity_type  (cfg_parity_type),
      .cfg_gap_bits     (cfg_gap_bits),
      .cts_n            (cts_n),
      .tx_data          (tx_data),
      .start_tx         (start_tx),
      .data_bit_num     (data_bit_num),
      .stop_bit_num     (stop_bit_num),
      .parity_en        (parity_en),
      .parity_type      (parity_type),
      .tx_done          (tx_done),
      .busy             (busy),
      .grant_id         (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tick: 2 cycles high, 2 low -> one tick event every 4 clocks
   logic [1:0] tick_phase;
   initial begin
      tick_phase = 2'd0;
      tick = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         tick_phase = tick_phase + 2'd1;
         tick = tick_phase[1];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic id, input logic [7:0] data, input logic [1:0] dbn,
                       input logic stop, input logic pe, input logic pt);
      exp_t e;
      e.id = id; e.data = data; e.dbn = dbn; e.stop = stop; e.pe = pe; e.pt = pt;
      sb_q.push_back(e);
   endtask

   // Monitor: grant scoreboard, pulse width, tick events inside START
   logic [1:0] mon_ready_q = 2'b00;
   logic       mon_tick_q  = 1'b0;
   logic       mon_start_q = 1'b0;
   int         start_ev    = 0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (req_ready != 2'b00) begin
            if (mon_ready_q != 2'b00)
               chk("ready_pulse_width", 32'(req_ready), 32'(0));
            if (sb_q.size() == 0) begin
               chk("unexpected_grant", 32'(req_ready), 32'(0));
            end else begin
               e = sb_q.pop_front();
               chk("grant",
                   {16'h0, req_ready, tx_data, grant_id, data_bit_num,
                    stop_bit_num, parity_en, parity_type},
                   {16'h0, (e.id ? 2'b10 : 2'b01), e.data, e.id, e.dbn,
                    e.stop, e.pe, e.pt});
            end
         end
         if (start_tx && tick && !mon_tick_q) start_ev++;
         if (mon_start_q && !start_tx) begin
            chk("start_tick_events", 32'(start_ev), 32'(1));
            start_ev = 0;
         end
      end
      mon_ready_q = req_ready;
      mon_tick_q  = tick;
      mon_start_q = start_tx;
   end

   task automatic wait_start();
      for (int i = 0; i < 200 && start_tx !== 1'b1; i++) @(negedge clk);
      chk("wait_start", 32'(start_tx), 32'(1));
   endtask

   task automatic wait_start_end();
      for (int i = 0; i < 200 && start_tx !== 1'b0; i++) @(negedge clk);
      chk("wait_start_end", 32'(start_tx), 32'(0));
   endtask

   // One frame with no gap: transmitter acknowledges a few cycles after start
   task automatic frame(input logic drop);
      wait_start();
      if (drop) req_valid = 2'b00;
      chk("busy_in_start", 32'(busy), 32'(1));
      wait_start_end();
      repeat (3) @(negedge clk);
      chk("busy_wait_done", 32'(busy), 32'(1));
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk("idle_after_done", 32'(busy), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cnt;
      logic tq;

      rst_n = 1'b1;
      req_valid = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00;
      cfg_data_bit_num = 2'b00; cfg_stop_bit_num = 1'b0;
      cfg_parity_en = 1'b0; cfg_parity_type = 1'b0; cfg_gap_bits = 4'd0;
      cts_n = 1'b1; tx_done = 1'b0;
      #1 rst_n = 1'b0;

      // Reset values, with a request already pending
      cfg_data_bit_num = 2'b10; cfg_stop_bit_num = 1'b1;
      cfg_parity_en = 1'b1; cfg_parity_type = 1'b1; cfg_gap_bits = 4'd0;
      req_valid = 2'b01; req_data0 = 8'hA5; cts_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_start_tx", 32'(start_tx), 32'(0));
      chk("rst_tx_data", 32'(tx_data), 32'(0));
      chk("rst_data_bit_num", 32'(data_bit_num), 32'(3));
      chk("rst_stop_parity", 32'({stop_bit_num, parity_en, parity_type}), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_grant_id", 32'(grant_id), 32'(1));

      // Single request; no grant in the first cycle after release
      push(1'b0, 8'hA5, 2'b10, 1'b1, 1'b1, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("no_grant_first_cycle", 32'(req_ready), 32'(0));
      frame(1'b1);

      // Both valid: alternation 1,0,1,0 (last owner was 0)
      cfg_data_bit_num = 2'b01; cfg_stop_bit_num = 1'b0;
      cfg_parity_en = 1'b0; cfg_parity_type = 1'b0;
      req_data0 = 8'h11; req_data1 = 8'h22;
      push(1'b1, 8'h22, 2'b01, 1'b0, 1'b0, 1'b0);
      push(1'b0, 8'h11, 2'b01, 1'b0, 1'b0, 1'b0);
      push(1'b1, 8'h22, 2'b01, 1'b0, 1'b0, 1'b0);
      push(1'b0, 8'h11, 2'b01, 1'b0, 1'b0, 1'b0);
      req_valid = 2'b11;
      frame(1'b0);
      frame(1'b0);
      frame(1'b0);
      frame(1'b1);

      // cts_n high blocks grants; release grants next cycle
      cts_n = 1'b1;
      req_data0 = 8'h33; req_data1 = 8'h44;
      req_valid = 2'b11;
      cnt = 0;
      repeat (1000) begin
         @(negedge clk);
         if (start_tx) cnt++;
      end
      chk("cts_hold_start", 32'(cnt), 32'(0));
      chk("cts_hold_busy", 32'(busy), 32'(0));
      push(1'b1, 8'h44, 2'b01, 1'b0, 1'b0, 1'b0);
      cts_n = 1'b0;
      @(negedge clk);
      chk("cts_release_grant", 32'(req_ready), 32'(2'b10));
      frame(1'b1);

      // Stale tx_done level and cfg changes mid-frame are ignored
      req_data0 = 8'h5A;
      push(1'b0, 8'h5A, 2'b01, 1'b0, 1'b0, 1'b0);
      req_valid = 2'b01;
      wait_start();
      req_valid = 2'b00;
      tx_done = 1'b1;
      wait_start_end();
      cfg_parity_en = 1'b1; cfg_gap_bits = 4'd3; cfg_data_bit_num = 2'b00;
      cts_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("done_level_ignored", 32'(busy), 32'(1));
      chk("parity_en_held", 32'(parity_en), 32'(0));
      chk("data_bit_num_held", 32'(data_bit_num), 32'(2'b01));
      tx_done = 1'b0;
      repeat (2) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk("gap_cfg_latched", 32'(busy), 32'(0));
      cfg_parity_en = 1'b0; cfg_data_bit_num = 2'b01; cts_n = 1'b0;

      // Gap of 2 bits: 32 tick events between done rise and next grant
      cfg_gap_bits = 4'd2;
      req_data0 = 8'h66; req_data1 = 8'h77;
      push(1'b1, 8'h77, 2'b01, 1'b0, 1'b0, 1'b0);
      push(1'b0, 8'h66, 2'b01, 1'b0, 1'b0, 1'b0);
      req_valid = 2'b11;
      wait_start();
      wait_start_end();
      repeat (3) @(negedge clk);
      tx_done = 1'b1;
      tq = tick;
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         tx_done = 1'b0;
         if (req_ready != 2'b00) break;
         if (tick && !tq) cnt++;
         tq = tick;
      end
      chk("gap_tick_events", 32'(cnt), 32'(32));
      req_valid = 2'b00;
      wait_start();
      wait_start_end();
      repeat (3) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk("busy_in_gap", 32'(busy), 32'(1));
      for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clk);
      chk("gap_end_idle", 32'(busy), 32'(0));
      cfg_gap_bits = 4'd0;

      // Async reset in WAIT_DONE, stale tx_done high across release
      req_data0 = 8'hC3;
      push(1'b0, 8'hC3, 2'b01, 1'b0, 1'b0, 1'b0);
      req_valid = 2'b01;
      wait_start();
      req_valid = 2'b00;
      wait_start_end();
      @(negedge clk);
      chk("in_wait_done", 32'(busy), 32'(1));
      #2 rst_n = 1'b0;
      tx_done = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'(0));
      chk("async_rst_tx_data", 32'(tx_data), 32'(0));
      chk("async_rst_grant_id", 32'(grant_id), 32'(1));
      chk("async_rst_cfg", 32'({data_bit_num, stop_bit_num, parity_en, parity_type}),
          32'(5'b11000));
      chk("async_rst_outs", 32'({req_ready, start_tx}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("stale_done_busy", 32'(busy), 32'(0));
      chk("stale_done_start", 32'(start_tx), 32'(0));
      tx_done = 1'b0;
      repeat (2) @(negedge clk);

      chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
